wdata_chan_mngr: RTL and testbench

// - Manager-side AXI write data channel: takes one 128-bit line plus 16-bit byte mask from the

---
 rtl/wdata_chan_mngr_pkg.sv | 19 +
 rtl/wdata_chan_mngr.sv | 133 +++++++++++++
 tb/tb_wdata_chan_mngr.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/wdata_chan_mngr_pkg.sv
// Shared definitions for the manager-side AXI write data channel.
// Holds the state encoding, beat counter width and mask-to-strobe polarity helper.
package wdata_chan_mngr_pkg;

    typedef enum logic [1:0] {
        MIDLE = 2'b00,
        MWAIT = 2'b01,
        MBRST = 2'b10,
        MDEFO = 2'b11
    } mstate_t;

    localparam int CNT_W = 2;

    // Queue mask marks suppressed bytes with 1; AXI strobe marks written bytes with 1.
    function automatic logic [3:0] mask2strb(input logic [3:0] m);
        return ~m;
    endfunction

endpackage

// File: rtl/wdata_chan_mngr.sv
// Manager-side AXI W channel: buffers one 128-bit line + byte mask and issues it
// as a 1..4 beat 32-bit burst once the address channel has released the data phase.
module wdata_chan_mngr
    import wdata_chan_mngr_pkg::*;
#(
    parameter int DW     = 32,
    parameter int LINE_W = 4 * DW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wdat_m_valid,
    output logic                  wdat_m_ready,
    input  logic [LINE_W-1:0]     wdat_m_data,
    input  logic [LINE_W/8-1:0]   wdat_m_mask,
    input  logic [CNT_W-1:0]      wdat_m_len,
    input  logic                  next_mrq,
    output logic                  wvalid,
    input  logic                  wready,
    output logic [DW-1:0]         wdata,
    output logic [DW/8-1:0]       wstrb,
    output logic                  wlast,
    output logic                  finish_mwd
);

    localparam int MASK_W  = LINE_W / 8;
    localparam int BSTRB_W = DW / 8;

    mstate_t             r_state;
    mstate_t             w_next;
    logic [LINE_W-1:0]   r_line;
    logic [MASK_W-1:0]   r_mask;
    logic [CNT_W-1:0]    r_len;
    logic [CNT_W-1:0]    r_cntr;
    logic                r_go_pend;
    logic                r_fin;

    logic                w_in_brst;
    logic                w_accept;
    logic                w_go;
    logic                w_last;
    logic                w_hs;
    logic [DW-1:0]       w_beat_data;
    logic [BSTRB_W-1:0]  w_beat_mask;

    // MDEFO is unreachable in normal operation and only rst leaves it.
    function automatic mstate_t next_state(input mstate_t st, input logic acc,
                                           input logic go, input logic done);
        mstate_t nx;
        nx = st;
        case (st)
            MIDLE:   if (acc)  nx = go ? MBRST : MWAIT;
            MWAIT:   if (go)   nx = MBRST;
            MBRST:   if (done) nx = MIDLE;
            default:           nx = MDEFO;
        endcase
        return nx;
    endfunction

    always_comb begin
        w_in_brst = (r_state == MBRST);
        w_accept  = (r_state == MIDLE) && wdat_m_valid;
        w_go      = r_go_pend || next_mrq;
        w_last    = (r_cntr == r_len);
        w_hs      = w_in_brst && wready;
        w_next    = next_state(r_state, w_accept, w_go, w_hs && w_last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MIDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_line    <= '0;
            r_mask    <= '0;
            r_len     <= '0;
            r_cntr    <= '0;
            r_go_pend <= 1'b0;
            r_fin     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_line <= wdat_m_data;
                r_mask <= wdat_m_mask;
                r_len  <= wdat_m_len;
            end
            if (w_hs) begin
                r_cntr <= w_last ? '0 : r_cntr + 1'b1;
            end
            // An early next_mrq is remembered (saturating) for the transaction it belongs to.
            if ((w_next == MBRST) && !w_in_brst) begin
                r_go_pend <= 1'b0;
            end else if (next_mrq && (w_in_brst || (r_state == MIDLE))) begin
                r_go_pend <= 1'b1;
            end
            r_fin <= w_hs && w_last;
        end
    end

    always_comb begin
        w_beat_data = '0;
        w_beat_mask = '0;
        case (r_cntr)
            2'd0: begin
                w_beat_data = r_line[0*DW +: DW];
                w_beat_mask = r_mask[0*BSTRB_W +: BSTRB_W];
            end
            2'd1: begin
                w_beat_data = r_line[1*DW +: DW];
                w_beat_mask = r_mask[1*BSTRB_W +: BSTRB_W];
            end
            2'd2: begin
                w_beat_data = r_line[2*DW +: DW];
                w_beat_mask = r_mask[2*BSTRB_W +: BSTRB_W];
            end
            default: begin
                w_beat_data = r_line[3*DW +: DW];
                w_beat_mask = r_mask[3*BSTRB_W +: BSTRB_W];
            end
        endcase
    end

    assign wdat_m_ready = (r_state == MIDLE);
    assign wvalid       = w_in_brst;
    assign wdata        = w_in_brst ? w_beat_data : '0;
    assign wstrb        = w_in_brst ? mask2strb(w_beat_mask) : '0;
    assign wlast        = w_in_brst && w_last;
    assign finish_mwd   = r_fin;

endmodule

// File: tb/tb_wdata_chan_mngr.sv
// Directed vector bench for wdata_chan_mngr: a per-cycle table plus hand sequences
// for backpressure, reset mid-burst and back-to-back transactions.
module tb_wdata_chan_mngr;

    typedef struct {
        logic         v;
        logic [127:0] d;
        logic [15:0]  m;
        logic [1:0]   len;
        logic         nm;
        logic         wr;
        logic         e_rdy;
        logic         e_wv;
        logic [31:0]  e_wd;
        logic [3:0]   e_ws;
        logic         e_wl;
        logic         e_fin;
    } vec_t;

    localparam logic [127:0] D1 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] D2 = 128'h00000000_00000000_BBBBBBBB_AAAAAAAA;
    localparam logic [127:0] D3 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;

    logic         clk = 1'b0;
    logic         rst;
    logic         wdat_m_valid;
    logic         wdat_m_ready;
    logic [127:0] wdat_m_data;
    logic [15:0]  wdat_m_mask;
    logic [1:0]   wdat_m_len;
    logic         next_mrq;
    logic         wvalid;
    logic         wready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         finish_mwd;

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl[19];

    wdata_chan_mngr dut (
        .clk          (clk),
        .rst          (rst),
        .wdat_m_valid (wdat_m_valid),
        .wdat_m_ready (wdat_m_ready),
        .wdat_m_data  (wdat_m_data),
        .wdat_m_mask  (wdat_m_mask),
        .wdat_m_len   (wdat_m_len),
        .next_mrq     (next_mrq),
        .wvalid       (wvalid),
        .wready       (wready),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .wlast        (wlast),
        .finish_mwd   (finish_mwd)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v, input logic [127:0] d, input logic [15:0] m,
                                input logic [1:0] len, input logic nm, input logic wr,
                                input logic rdy, input logic wv, input logic [31:0] wd,
                                input logic [3:0] ws, input logic wl, input logic fin);
        vec_t t;
        t.v = v; t.d = d; t.m = m; t.len = len; t.nm = nm; t.wr = wr;
        t.e_rdy = rdy; t.e_wv = wv; t.e_wd = wd; t.e_ws = ws; t.e_wl = wl; t.e_fin = fin;
        return t;
    endfunction

    // Called at a negedge: check outputs of the current cycle, drive inputs for the next edge.
    task automatic apply(input string name, input vec_t t);
        n_vec++;
        if (wdat_m_ready !== t.e_rdy || wvalid !== t.e_wv || wdata !== t.e_wd ||
            wstrb !== t.e_ws || wlast !== t.e_wl || finish_mwd !== t.e_fin) begin
            n_err++;
            $display("FAIL %s: got rdy=%b wv=%b wd=%h ws=%h wl=%b fin=%b, want rdy=%b wv=%b wd=%h ws=%h wl=%b fin=%b",
                     name, wdat_m_ready, wvalid, wdata, wstrb, wlast, finish_mwd,
                     t.e_rdy, t.e_wv, t.e_wd, t.e_ws, t.e_wl, t.e_fin);
        end
        wdat_m_valid = t.v;
        wdat_m_data  = t.d;
        wdat_m_mask  = t.m;
        wdat_m_len   = t.len;
        next_mrq     = t.nm;
        wready       = t.wr;
        @(negedge clk);
    endtask

    initial begin
        // Basic 4-beat burst with next_mrq arriving first
        tbl[0]  = mk(0, 0,  16'h0000, 0, 1, 1,  1, 0, 32'h0, 4'h0, 0, 0);
        tbl[1]  = mk(1, D1, 16'h0000, 3, 0, 1,  1, 0, 32'h0, 4'h0, 0, 0);
        tbl[2]  = mk(0, 0,  16'h0000, 0, 0, 1,  0, 1, 32'h11111111, 4'hF, 0, 0);
        tbl[3]  = mk(0, 0,  16'h0000, 0, 0, 1,  0, 1, 32'h22222222, 4'hF, 0, 0);
        tbl[4]  = mk(0, 0,  16'h0000, 0, 0, 1,  0, 1, 32'h33333333, 4'hF, 0, 0);
        tbl[5]  = mk(0, 0,  16'h0000, 0, 0, 1,  0, 1, 32'h44444444, 4'hF, 1, 0);
        tbl[6]  = mk(0, 0,  16'h0000, 0, 0, 1,  1, 0, 32'h0, 4'h0, 0, 1);
        // Short masked burst, captured together with next_mrq
        tbl[7]  = mk(1, D2, 16'h00F3, 1, 1, 1,  1, 0, 32'h0, 4'h0, 0, 0);
        tbl[8]  = mk(0, 0,  16'h0000, 0, 0, 1,  0, 1, 32'hAAAAAAAA, 4'hC, 0, 0);
        tbl[9]  = mk(0, 0,  16'h0000, 0, 0, 1,  0, 1, 32'hBBBBBBBB, 4'h0, 1, 0);
        // Next request accepted right away, next_mrq 5 cycles later
        tbl[10] = mk(1, D3, 16'h0000, 0, 0, 0,  1, 0, 32'h0, 4'h0, 0, 1);
        tbl[11] = mk(0, 0,  16'h0000, 0, 0, 0,  0, 0, 32'h0, 4'h0, 0, 0);
        tbl[12] = mk(0, 0,  16'h0000, 0, 0, 0,  0, 0, 32'h0, 4'h0, 0, 0);
        tbl[13] = mk(0, 0,  16'h0000, 0, 0, 0,  0, 0, 32'h0, 4'h0, 0, 0);
        tbl[14] = mk(0, 0,  16'h0000, 0, 0, 0,  0, 0, 32'h0, 4'h0, 0, 0);
        tbl[15] = mk(0, 0,  16'h0000, 0, 1, 0,  0, 0, 32'h0, 4'h0, 0, 0);
        tbl[16] = mk(0, 0,  16'h0000, 0, 0, 0,  0, 1, 32'h9ABCDEF0, 4'hF, 1, 0);
        tbl[17] = mk(0, 0,  16'h0000, 0, 0, 1,  0, 1, 32'h9ABCDEF0, 4'hF, 1, 0);
        tbl[18] = mk(0, 0,  16'h0000, 0, 0, 0,  1, 0, 32'h0, 4'h0, 0, 1);

        rst = 1'b1;
        wdat_m_valid = 1'b0; wdat_m_data = '0; wdat_m_mask = '0; wdat_m_len = '0;
        next_mrq = 1'b0; wready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            apply($sformatf("tbl%0d", i), tbl[i]);
        end

        // Backpressure: wready low for 3 cycles on beat 1
        apply("bp0", mk(0, 0,  0, 0, 1, 1,  1, 0, 32'h0, 4'h0, 0, 0));
        apply("bp1", mk(1, D1, 0, 3, 0, 1,  1, 0, 32'h0, 4'h0, 0, 0));
        apply("bp2", mk(0, 0,  0, 0, 0, 1,  0, 1, 32'h11111111, 4'hF, 0, 0));
        apply("bp3", mk(0, 0,  0, 0, 0, 0,  0, 1, 32'h22222222, 4'hF, 0, 0));
        apply("bp4", mk(0, 0,  0, 0, 0, 0,  0, 1, 32'h22222222, 4'hF, 0, 0));
        apply("bp5", mk(0, 0,  0, 0, 0, 0,  0, 1, 32'h22222222, 4'hF, 0, 0));
        apply("bp6", mk(0, 0,  0, 0, 0, 1,  0, 1, 32'h22222222, 4'hF, 0, 0));
        apply("bp7", mk(0, 0,  0, 0, 0, 1,  0, 1, 32'h33333333, 4'hF, 0, 0));
        apply("bp8", mk(0, 0,  0, 0, 0, 1,  0, 1, 32'h44444444, 4'hF, 1, 0));
        apply("bp9", mk(0, 0,  0, 0, 0, 0,  1, 0, 32'h0, 4'h0, 0, 1));

        // Reset asserted during beat 2, then a fresh burst from beat 0
        apply("rs0", mk(1, D1, 0, 3, 1, 1,  1, 0, 32'h0, 4'h0, 0, 0));
        apply("rs1", mk(0, 0,  0, 0, 0, 1,  0, 1, 32'h11111111, 4'hF, 0, 0));
        apply("rs2", mk(0, 0,  0, 0, 0, 1,  0, 1, 32'h22222222, 4'hF, 0, 0));
        rst = 1'b1;
        apply("rs3", mk(0, 0,  0, 0, 0, 1,  0, 1, 32'h33333333, 4'hF, 0, 0));
        rst = 1'b0;
        apply("rs4", mk(1, D1, 0, 3, 1, 1,  1, 0, 32'h0, 4'h0, 0, 0));
        apply("rs5", mk(0, 0,  0, 0, 0, 1,  0, 1, 32'h11111111, 4'hF, 0, 0));
        apply("rs6", mk(0, 0,  0, 0, 0, 1,  0, 1, 32'h22222222, 4'hF, 0, 0));
        apply("rs7", mk(0, 0,  0, 0, 0, 1,  0, 1, 32'h33333333, 4'hF, 0, 0));
        apply("rs8", mk(0, 0,  0, 0, 0, 1,  0, 1, 32'h44444444, 4'hF, 1, 0));
        apply("rs9", mk(0, 0,  0, 0, 0, 0,  1, 0, 32'h0, 4'h0, 0, 1));

        // Back-to-back: next_mrq during burst A releases burst B immediately
        apply("bb0", mk(1, D2, 16'h00F3, 1, 1, 1,  1, 0, 32'h0, 4'h0, 0, 0));
        apply("bb1", mk(0, 0,  0, 0, 1, 1,  0, 1, 32'hAAAAAAAA, 4'hC, 0, 0));
        apply("bb2", mk(0, 0,  0, 0, 0, 1,  0, 1, 32'hBBBBBBBB, 4'h0, 1, 0));
        apply("bb3", mk(1, D3, 0, 0, 0, 1,  1, 0, 32'h0, 4'h0, 0, 1));
        apply("bb4", mk(0, 0,  0, 0, 0, 1,  0, 1, 32'h9ABCDEF0, 4'hF, 1, 0));
        apply("bb5", mk(1, D1, 0, 0, 0, 1,  1, 0, 32'h0, 4'h0, 0, 1));
        apply("bb6", mk(0, 0,  0, 0, 0, 1,  0, 0, 32'h0, 4'h0, 0, 0));
        apply("bb7", mk(0, 0,  0, 0, 1, 1,  0, 0, 32'h0, 4'h0, 0, 0));
        apply("bb8", mk(0, 0,  0, 0, 0, 1,  0, 1, 32'h11111111, 4'hF, 1, 0));
        apply("bb9", mk(0, 0,  0, 0, 0, 0,  1, 0, 32'h0, 4'h0, 0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
